// File: rtl/microwire_pkg.sv
// Shared constants and encodings for the Microwire EEPROM emulator.
// Opcodes, extended sub-codes, FSM states and latched commands.
package microwire_pkg;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b11;
  localparam logic [1:0] OP_EXT   = 2'b00;

  localparam logic [1:0] EXT_EWDS = 2'b00;
  localparam logic [1:0] EXT_WRAL = 2'b01;
  localparam logic [1:0] EXT_ERAL = 2'b10;
  localparam logic [1:0] EXT_EWEN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_ADDR,
    ST_RD,
    ST_WRD,
    ST_WAIT_CS,
    ST_PROG
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_WRITE,
    CMD_ERASE,
    CMD_WRAL,
    CMD_ERAL,
    CMD_EWEN,
    CMD_EWDS
  } cmd_t;

endpackage

// File: rtl/microwire_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with
// rise/fall pulses derived from the synchronised copy.
module microwire_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [2:0] sh_q;
  logic [2:0] sh_d;

  // two sync stages plus one history stage for edges
  always_comb begin
    sh_d = {sh_q[1:0], din};
  end

  // shift register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= {3{RST_VAL}};
    else     sh_q <= sh_d;
  end

  assign sync = sh_q[1];
  assign rise = sh_q[1] & ~sh_q[2];
  assign fall = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/microwire_eeprom_emu.sv
// 93Cxx-style Microwire slave emulator in front of a
// single-port synchronous buffer RAM.
module microwire_eeprom_emu
  import microwire_pkg::*;
#(
  parameter int   ADDR_W      = 7,
  parameter int   DATA_W      = 8,
  parameter int   PROG_CYCLES = 16,
  parameter logic WEN_RESET   = 1'b1
) (
  input  logic              SYSCLK_IN,
  input  logic              RESET_IN,
  input  logic              CS_IN,
  input  logic              SK_IN,
  input  logic              DI_IN,
  output logic              DO_OUT,
  output logic              MEM_WE_OUT,
  output logic [ADDR_W-1:0] MEM_ADDR_OUT,
  output logic [DATA_W-1:0] MEM_DIN_OUT,
  input  logic [DATA_W-1:0] MEM_DOUT_IN,
  output logic              BUSY_OUT,
  output logic              WEN_OUT
);

  localparam int MW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CW = $clog2(MW + 1);
  localparam int PW = $clog2(PROG_CYCLES + 1);

  logic cs_s, cs_rise, cs_fall;
  logic sk_s, sk_rise, sk_fall;
  logic di_s, di_rise, di_fall;
  logic unused_edges;

  microwire_sync_edge u_cs (
    .clk(SYSCLK_IN), .rst(RESET_IN), .din(CS_IN),
    .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  microwire_sync_edge u_sk (
    .clk(SYSCLK_IN), .rst(RESET_IN), .din(SK_IN),
    .sync(sk_s), .rise(sk_rise), .fall(sk_fall)
  );
  microwire_sync_edge u_di (
    .clk(SYSCLK_IN), .rst(RESET_IN), .din(DI_IN),
    .sync(di_s), .rise(di_rise), .fall(di_fall)
  );

  assign unused_edges = ^{cs_rise, cs_fall, sk_s, di_rise, di_fall};

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic [1:0]        opc_q, opc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wsh_q, wsh_d;
  logic [DATA_W:0]   rsh_q, rsh_d;
  logic [DATA_W-1:0] nxt_q, nxt_d;
  logic [1:0]        pend_q, pend_d;
  logic              pfirst_q, pfirst_d;
  logic              wen_q, wen_d;
  logic              busy_q, busy_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mdin_q, mdin_d;
  logic              do_q, do_d;
  logic              sweep_q, sweep_d;

  logic [ADDR_W-1:0] addr_shift;
  logic              cs_drop;

  assign addr_shift = {addr_q[ADDR_W-2:0], di_s};
  assign cs_drop    = !cs_s && (state_q inside
                      {ST_IDLE, ST_OPC, ST_ADDR, ST_RD, ST_WRD});

  // frame decode, read streaming, commit and programming sweep
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    bcnt_d   = bcnt_q;
    opc_d    = opc_q;
    addr_d   = addr_q;
    wsh_d    = wsh_q;
    rsh_d    = rsh_q;
    nxt_d    = nxt_q;
    pend_d   = {pend_q[0], 1'b0};
    pfirst_d = pfirst_q;
    wen_d    = wen_q;
    busy_d   = busy_q;
    pcnt_d   = pcnt_q;
    we_d     = 1'b0;
    maddr_d  = maddr_q;
    mdin_d   = mdin_q;
    do_d     = 1'b1;
    sweep_d  = sweep_q;

    case (state_q)
      ST_IDLE: begin
        if (cs_s && sk_rise && di_s) begin
          state_d = ST_OPC;
          bcnt_d  = '0;
        end
      end
      ST_OPC: begin
        if (sk_rise) begin
          opc_d = {opc_q[0], di_s};
          if (bcnt_q == CW'(1)) begin
            state_d = ST_ADDR;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + CW'(1);
          end
        end
      end
      ST_ADDR: begin
        if (sk_rise) begin
          addr_d = addr_shift;
          bcnt_d = bcnt_q + CW'(1);
          if (bcnt_q == CW'(ADDR_W - 1)) begin
            bcnt_d = '0;
            unique case (opc_q)
              OP_READ: begin
                state_d  = ST_RD;
                maddr_d  = addr_shift;
                pend_d   = 2'b01;
                pfirst_d = 1'b1;
              end
              OP_WRITE: begin
                state_d = ST_WRD;
                cmd_d   = CMD_WRITE;
              end
              OP_ERASE: begin
                state_d = ST_WAIT_CS;
                cmd_d   = CMD_ERASE;
              end
              OP_EXT: begin
                unique case (addr_shift[ADDR_W-1 -: 2])
                  EXT_EWEN: begin
                    state_d = ST_WAIT_CS;
                    cmd_d   = CMD_EWEN;
                  end
                  EXT_EWDS: begin
                    state_d = ST_WAIT_CS;
                    cmd_d   = CMD_EWDS;
                  end
                  EXT_WRAL: begin
                    state_d = ST_WRD;
                    cmd_d   = CMD_WRAL;
                  end
                  EXT_ERAL: begin
                    state_d = ST_WAIT_CS;
                    cmd_d   = CMD_ERAL;
                  end
                endcase
              end
            endcase
          end
        end
      end
      ST_RD: begin
        do_d = do_q;
        if (pend_q[1]) begin
          if (pfirst_q) begin
            rsh_d    = {1'b0, MEM_DOUT_IN};
            pfirst_d = 1'b0;
            maddr_d  = maddr_q + ADDR_W'(1);
            pend_d   = 2'b01;
          end else begin
            nxt_d = MEM_DOUT_IN;
          end
        end
        if (sk_fall) begin
          do_d = rsh_q[DATA_W];
          if (bcnt_q == CW'(DATA_W)) begin
            rsh_d   = {nxt_q, 1'b0};
            bcnt_d  = CW'(1);
            maddr_d = maddr_q + ADDR_W'(1);
            pend_d  = 2'b01;
          end else begin
            rsh_d  = {rsh_q[DATA_W-1:0], 1'b0};
            bcnt_d = bcnt_q + CW'(1);
          end
        end
      end
      ST_WRD: begin
        if (sk_rise) begin
          wsh_d  = {wsh_q[DATA_W-2:0], di_s};
          bcnt_d = bcnt_q + CW'(1);
          if (bcnt_q == CW'(DATA_W - 1)) begin
            state_d = ST_WAIT_CS;
          end
        end
      end
      ST_WAIT_CS: begin
        if (!cs_s) begin
          state_d = ST_IDLE;
          cmd_d   = CMD_NONE;
          bcnt_d  = '0;
          case (cmd_q)
            CMD_WRITE, CMD_ERASE: begin
              if (wen_q) begin
                state_d = ST_PROG;
                we_d    = 1'b1;
                maddr_d = addr_q;
                mdin_d  = (cmd_q == CMD_WRITE) ? wsh_q : '1;
                sweep_d = 1'b0;
              end
            end
            CMD_WRAL, CMD_ERAL: begin
              if (wen_q) begin
                state_d = ST_PROG;
                we_d    = 1'b1;
                busy_d  = 1'b1;
                maddr_d = '0;
                mdin_d  = (cmd_q == CMD_WRAL) ? wsh_q : '1;
                sweep_d = 1'b1;
              end
            end
            CMD_EWEN: wen_d = 1'b1;
            CMD_EWDS: wen_d = 1'b0;
            default: ;
          endcase
        end
      end
      ST_PROG: begin
        do_d = !cs_s;
        if (we_q && sweep_q && (maddr_q != '1)) begin
          we_d    = 1'b1;
          busy_d  = 1'b1;
          maddr_d = maddr_q + ADDR_W'(1);
        end else if (we_q) begin
          busy_d = 1'b1;
          pcnt_d = PW'(PROG_CYCLES - 1);
        end else if (pcnt_q != '0) begin
          busy_d = 1'b1;
          pcnt_d = pcnt_q - PW'(1);
        end else begin
          busy_d  = 1'b0;
          do_d    = 1'b1;
          sweep_d = 1'b0;
          state_d = cs_s ? ST_WAIT_CS : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cs_drop) begin
      state_d = ST_IDLE;
      cmd_d   = CMD_NONE;
      bcnt_d  = '0;
      pend_d  = '0;
      do_d    = 1'b1;
    end
  end

  // state and datapath registers
  always_ff @(posedge SYSCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_NONE;
      bcnt_q   <= '0;
      opc_q    <= '0;
      addr_q   <= '0;
      wsh_q    <= '0;
      rsh_q    <= '0;
      nxt_q    <= '0;
      pend_q   <= '0;
      pfirst_q <= 1'b0;
      wen_q    <= WEN_RESET;
      busy_q   <= 1'b0;
      pcnt_q   <= '0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mdin_q   <= '0;
      do_q     <= 1'b1;
      sweep_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      bcnt_q   <= bcnt_d;
      opc_q    <= opc_d;
      addr_q   <= addr_d;
      wsh_q    <= wsh_d;
      rsh_q    <= rsh_d;
      nxt_q    <= nxt_d;
      pend_q   <= pend_d;
      pfirst_q <= pfirst_d;
      wen_q    <= wen_d;
      busy_q   <= busy_d;
      pcnt_q   <= pcnt_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      mdin_q   <= mdin_d;
      do_q     <= do_d;
      sweep_q  <= sweep_d;
    end
  end

  assign DO_OUT       = do_q;
  assign MEM_WE_OUT   = we_q;
  assign MEM_ADDR_OUT = maddr_q;
  assign MEM_DIN_OUT  = mdin_q;
  assign BUSY_OUT     = busy_q;
  assign WEN_OUT      = wen_q;

endmodule
